// File: rtl/ldpc_pkg.sv
// Shared types and message helpers for the layered-LDPC check-node datapath.
// Messages are MSG_W-bit two's complement; magnitudes are MSG_W-1 bits.
package ldpc_pkg;

   localparam int MSG_W = 8;
   localparam logic [MSG_W-2:0] MAG_MAX = '1;

   typedef enum logic {
      ACC  = 1'b0,
      EMIT = 1'b1
   } state_t;

   function automatic logic [MSG_W-2:0] sat_abs(input logic [MSG_W-1:0] x);
      logic [MSG_W-1:0] n;
      n = -x;
      if (!x[MSG_W-1])
         return x[MSG_W-2:0];
      else if (n[MSG_W-1])
         return MAG_MAX;   // the most negative value negates to itself
      else
         return n[MSG_W-2:0];
   endfunction

   function automatic logic [MSG_W-1:0] to_signed(input logic s, input logic [MSG_W-2:0] mag);
      logic [MSG_W-1:0] v;
      v = {1'b0, mag};
      return s ? -v : v;
   endfunction

endpackage

// File: rtl/cnu_lane.sv
// One check node: tracks the two smallest magnitudes, the argmin edge, sign parity
// and a per-edge sign bank, then forms offset min-sum outputs edge by edge.
module cnu_lane
   import ldpc_pkg::*;
#(
   parameter int DC     = 6,
   parameter int IDX_W  = 3,
   parameter int OFFSET = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acc_en,
   input  logic             clr,
   input  logic             emit,
   input  logic [IDX_W-1:0] cnt,
   input  logic [MSG_W-1:0] vtc,
   output logic [MSG_W-1:0] ctv
);

   localparam logic [MSG_W-2:0] OFF = OFFSET[MSG_W-2:0];

   logic [MSG_W-2:0] min1_reg, min2_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             parity_reg;
   logic [DC-1:0]    sign_reg;

   logic [MSG_W-2:0] mag_in;
   logic             sign_in;
   logic [MSG_W-2:0] sel_mag, out_mag;

   assign mag_in  = sat_abs(vtc);
   assign sign_in = vtc[MSG_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min1_reg   <= MAG_MAX;
         min2_reg   <= MAG_MAX;
         idx_reg    <= '0;
         parity_reg <= 1'b0;
         sign_reg   <= '0;
      end else if (clr) begin
         min1_reg   <= MAG_MAX;
         min2_reg   <= MAG_MAX;
         idx_reg    <= '0;
         parity_reg <= 1'b0;
      end else if (acc_en) begin
         // strict compares: ties keep the earliest argmin and push min1 into min2
         if (mag_in < min1_reg) begin
            min2_reg <= min1_reg;
            min1_reg <= mag_in;
            idx_reg  <= cnt;
         end else if (mag_in < min2_reg) begin
            min2_reg <= mag_in;
         end
         parity_reg    <= parity_reg ^ sign_in;
         sign_reg[cnt] <= sign_in;
      end
   end

   always_comb begin
      sel_mag = (cnt == idx_reg) ? min2_reg : min1_reg;
      out_mag = (sel_mag > OFF) ? (sel_mag - OFF) : '0;
      ctv     = emit ? to_signed(parity_reg ^ sign_reg[cnt], out_mag) : '0;
   end

endmodule

// File: rtl/cnu_minsum.sv
// Serial offset min-sum check-node unit: DC beats of D-lane input, then DC beats
// of check-to-variable output. The FSM and edge counter are shared by all lanes.
module cnu_minsum
   import ldpc_pkg::*;
#(
   parameter int data_w = MSG_W,
   parameter int D      = 5,
   parameter int DC     = 6,
   parameter int IDX_W  = 3,
   parameter int OFFSET = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [data_w*D-1:0] vtc_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [data_w*D-1:0] ctv_out,
   output logic                out_last
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(DC - 1);

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] cnt_reg, cnt_next;
   logic             acc_en, clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ACC;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      acc_en     = 1'b0;
      clr        = 1'b0;
      case (state_reg)
         ACC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_en = 1'b1;
               if (cnt_reg == LAST) begin
                  cnt_next   = '0;
                  state_next = EMIT;
               end else begin
                  cnt_next = cnt_reg + IDX_W'(1);
               end
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            out_last  = (cnt_reg == LAST);
            if (out_ready) begin
               if (cnt_reg == LAST) begin
                  clr        = 1'b1;
                  cnt_next   = '0;
                  state_next = ACC;
               end else begin
                  cnt_next = cnt_reg + IDX_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   generate
      for (genvar gi = 0; gi < D; gi++) begin : g_lane
         cnu_lane #(
            .DC     (DC),
            .IDX_W  (IDX_W),
            .OFFSET (OFFSET)
         ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .acc_en (acc_en),
            .clr    (clr),
            .emit   (out_valid),
            .cnt    (cnt_reg),
            .vtc    (vtc_in[gi*data_w +: data_w]),
            .ctv    (ctv_out[gi*data_w +: data_w])
         );
      end
   endgenerate

endmodule

// File: tb/tb_cnu_minsum.sv
// Randomized bench for cnu_minsum: two instances (offset 0 and 1) share stimulus and
// are checked per output edge against a row-level min-sum reference model.
module tb_cnu_minsum;

   localparam int W  = 8;
   localparam int NL = 5;
   localparam int NE = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [W*NL-1:0] vtc_in;
   logic            out_ready;

   logic            in_ready0, out_valid0, out_last0;
   logic [W*NL-1:0] ctv0;
   logic            in_ready1, out_valid1, out_last1;
   logic [W*NL-1:0] ctv1;

   int checks = 0;
   int errors = 0;
   int row [NE][NL];

   always #5 clk = ~clk;

   cnu_minsum #(.data_w(W), .D(NL), .DC(NE), .IDX_W(3), .OFFSET(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .vtc_in(vtc_in),
      .out_valid(out_valid0), .out_ready(out_ready), .ctv_out(ctv0), .out_last(out_last0)
   );

   cnu_minsum #(.data_w(W), .D(NL), .DC(NE), .IDX_W(3), .OFFSET(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .vtc_in(vtc_in),
      .out_valid(out_valid1), .out_ready(out_ready), .ctv_out(ctv1), .out_last(out_last1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int mag_of(input int x);
      if (x == -128) return 127;
      return (x < 0) ? -x : x;
   endfunction

   // Every output excludes its own edge: smallest magnitude among the other edges,
   // sign equal to the xor of the other edges' signs.
   function automatic logic [W*NL-1:0] expect_vec(input int k, input int off);
      logic [W*NL-1:0] v;
      int idx, m1, m2, par, sel, val;
      v = '0;
      for (int l = 0; l < NL; l++) begin
         idx = 0;
         m1  = mag_of(row[0][l]);
         for (int j = 1; j < NE; j++)
            if (mag_of(row[j][l]) < m1) begin
               m1  = mag_of(row[j][l]);
               idx = j;
            end
         m2 = 1000;
         for (int j = 0; j < NE; j++)
            if (j != idx && mag_of(row[j][l]) < m2) m2 = mag_of(row[j][l]);
         par = 0;
         for (int j = 0; j < NE; j++) par ^= (row[j][l] < 0) ? 1 : 0;
         sel = ((k == idx) ? m2 : m1) - off;
         if (sel < 0) sel = 0;
         val = ((par ^ ((row[k][l] < 0) ? 1 : 0)) != 0) ? -sel : sel;
         v[l*W +: W] = W'(val);
      end
      return v;
   endfunction

   task automatic load_directed();
      int l0 [NE] = '{10, -3, 7, 20, 5, 9};
      int l2 [NE] = '{4, 4, 9, 9, 9, 9};
      for (int k = 0; k < NE; k++) begin
         row[k][0] = l0[k];
         row[k][1] = -128;
         row[k][2] = l2[k];
         row[k][3] = 0;
         row[k][4] = 0;
      end
   endtask

   task automatic load_random();
      for (int k = 0; k < NE; k++)
         for (int l = 0; l < NL; l++)
            case ($urandom_range(0, 4))
               0: row[k][l] = -128;
               1: row[k][l] = 127;
               2: row[k][l] = int'($urandom_range(0, 10)) - 5;
               default: row[k][l] = int'($urandom_range(0, 255)) - 128;
            endcase
   endtask

   task automatic send_row(input int nbeats);
      int t;
      for (int k = 0; k < nbeats; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         for (int l = 0; l < NL; l++) vtc_in[l*W +: W] = W'(row[k][l]);
         in_valid = 1'b1;
         t = 0;
         while (!in_ready0 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         if (!in_ready0) check("in_ready_timeout", 64'(in_ready0), 64'd1);
         @(posedge clk); #1;
      end
      // keep presenting junk so any leak into EMIT would corrupt the results
      in_valid = 1'b1;
      vtc_in   = {$urandom, $urandom};
   endtask

   task automatic receive_row(input int rnum);
      int t;
      logic [W*NL-1:0] e0, e1;
      check("latency_valid0", 64'(out_valid0), 64'd1);
      check("latency_valid1", 64'(out_valid1), 64'd1);
      for (int k = 0; k < NE; k++) begin
         e0 = expect_vec(k, 0);
         e1 = expect_vec(k, 1);
         t  = 0;
         forever begin
            out_ready = ($urandom_range(0, 3) != 0) || (t >= 8);
            if (k == 2 && t < 3) out_ready = 1'b0;
            check($sformatf("no_overlap_r%0d_e%0d", rnum, k), 64'(in_ready0 | in_ready1), 64'd0);
            check($sformatf("out_valid_r%0d_e%0d", rnum, k), 64'(out_valid0 & out_valid1), 64'd1);
            check($sformatf("ctv_off0_r%0d_e%0d", rnum, k), 64'(ctv0), 64'(e0));
            check($sformatf("ctv_off1_r%0d_e%0d", rnum, k), 64'(ctv1), 64'(e1));
            check($sformatf("out_last_r%0d_e%0d", rnum, k), {62'd0, out_last0, out_last1},
                  (k == NE - 1) ? 64'd3 : 64'd0);
            if (out_ready) begin
               @(posedge clk); #1;
               break;
            end
            @(posedge clk); #1;
            t++;
         end
      end
      out_ready = 1'b0;
      check($sformatf("row_end_valid_r%0d", rnum), 64'(out_valid0 | out_valid1), 64'd0);
      check($sformatf("row_end_ready_r%0d", rnum), 64'(in_ready0 & in_ready1), 64'd1);
      $display("row %0d: %0d output edges checked", rnum, NE);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      vtc_in    = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready0 & in_ready1), 64'd1);
      check("rst_out_valid", 64'(out_valid0 | out_valid1), 64'd0);
      check("rst_out_last", 64'(out_last0 | out_last1), 64'd0);
      check("rst_ctv", 64'(ctv0 | ctv1), 64'd0);
      rst = 1'b0;

      load_directed();
      send_row(NE);
      receive_row(0);

      // partial row discarded by reset, then the directed row again
      load_random();
      send_row(3);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", 64'(out_valid0 | out_valid1), 64'd0);
      check("midrst_in_ready", 64'(in_ready0 & in_ready1), 64'd1);
      check("midrst_ctv", 64'(ctv0 | ctv1), 64'd0);
      rst = 1'b0;
      load_directed();
      send_row(NE);
      receive_row(1);

      for (int r = 2; r < 22; r++) begin
         load_random();
         send_row(NE);
         receive_row(r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
